// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory pipeline stage.
package dm_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2
  } dm_state_e;

  localparam logic DM_WRITE = 1'b1;
  localparam logic DM_READ  = 1'b0;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port word array: synchronous write, asynchronous read, no reset.
module data_mem_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_stage.sv
// Data-memory pipeline stage: load/store or ALU pass-through with configurable access latency,
// stall handshake and a post-reset hardware clear of the array.
module data_mem_stage
  import dm_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] DM_data,
  input  logic              mem_rw_ex,
  input  logic              mem_en_ex,
  input  logic              mem_mux_sel_dm,
  output logic [DATA_W-1:0] ans_dm,
  output logic              dm_busy,
  output logic              dm_valid
);

  localparam int unsigned CNT_W = min1_clog2(WAIT_CYC + 1);
  localparam int unsigned IDX_W = min1_clog2(DEPTH);
  localparam logic [IDX_W-1:0]  PTR_LAST  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   RANGE_LIM = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(WAIT_CYC - 1);

  if (ADDR_W > DATA_W) begin : g_bad_addr_w
    $error("data_mem_stage: ADDR_W must not exceed DATA_W");
  end
  if (DEPTH < 1 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
    $error("data_mem_stage: DEPTH must be in 1..2**ADDR_W");
  end

  dm_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0] lat_ans_q, lat_ans_d;
  logic [DATA_W-1:0] lat_data_q, lat_data_d;
  logic              lat_rw_q, lat_rw_d;
  logic              lat_sel_q, lat_sel_d;
  logic [DATA_W-1:0] ans_dm_q, ans_dm_d;
  logic              valid_q, valid_d;

  // Access operands: live inputs for a single-cycle access, latched copy while waiting.
  logic              in_wait;
  logic [DATA_W-1:0] acc_ans, acc_data;
  logic              acc_rw, acc_sel;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_in_range;
  logic [DATA_W-1:0] rd_data, acc_result;
  logic              do_access;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign in_wait      = (state_q == ST_WAIT);
  assign acc_ans      = in_wait ? lat_ans_q  : ans_ex;
  assign acc_data     = in_wait ? lat_data_q : DM_data;
  assign acc_rw       = in_wait ? lat_rw_q   : mem_rw_ex;
  assign acc_sel      = in_wait ? lat_sel_q  : mem_mux_sel_dm;
  assign acc_addr     = acc_ans[ADDR_W-1:0];
  assign acc_in_range = ({1'b0, acc_addr} < RANGE_LIM);
  assign rd_data      = acc_in_range ? ram_rdata : '0;
  assign acc_result   = (acc_rw == DM_READ && acc_sel) ? rd_data : acc_ans;

  assign do_access = (state_q == ST_IDLE && mem_en_ex && WAIT_CYC == 0) ||
                     (in_wait && cnt_q == '0);

  assign ram_we    = (state_q == ST_CLEAR) ||
                     (do_access && acc_rw == DM_WRITE && acc_in_range);
  assign ram_addr  = (state_q == ST_CLEAR) ? ptr_q : acc_addr[IDX_W-1:0];
  assign ram_wdata = (state_q == ST_CLEAR) ? '0 : acc_data;

  data_mem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    lat_ans_d  = lat_ans_q;
    lat_data_d = lat_data_q;
    lat_rw_d   = lat_rw_q;
    lat_sel_d  = lat_sel_q;
    ans_dm_d   = ans_dm_q;
    valid_d    = 1'b0;
    dm_busy    = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        dm_busy = 1'b1;
        ptr_d   = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (!mem_en_ex) begin
          ans_dm_d = ans_ex;
          valid_d  = 1'b1;
        end else if (WAIT_CYC == 0) begin
          ans_dm_d = acc_result;
          valid_d  = 1'b1;
        end else begin
          dm_busy    = 1'b1;
          lat_ans_d  = ans_ex;
          lat_data_d = DM_data;
          lat_rw_d   = mem_rw_ex;
          lat_sel_d  = mem_mux_sel_dm;
          cnt_d      = CNT_LOAD;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          dm_busy = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          ans_dm_d = acc_result;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        dm_busy = 1'b1;
        ptr_d   = '0;
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      ptr_q      <= '0;
      lat_ans_q  <= '0;
      lat_data_q <= '0;
      lat_rw_q   <= DM_READ;
      lat_sel_q  <= 1'b0;
      ans_dm_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      lat_ans_q  <= lat_ans_d;
      lat_data_q <= lat_data_d;
      lat_rw_q   <= lat_rw_d;
      lat_sel_q  <= lat_sel_d;
      ans_dm_q   <= ans_dm_d;
      valid_q    <= valid_d;
    end
  end

  assign ans_dm   = ans_dm_q;
  assign dm_valid = valid_q;

endmodule
